// File: rtl/pe_stream_sequencer.sv
// Joins up to three operand streams into one PE tile. Fires the PE when every
// enabled operand is present, bypasses aligned control tokens and buffers results.
module pe_stream_sequencer #(
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DATA_W:0]   DONE_TOKEN = 'h10100,
  parameter int                CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [2:0]        in_mask,
  input  logic [DATA_W:0]   data0,
  input  logic              data0_valid,
  output logic              data0_ready,
  input  logic [DATA_W:0]   data1,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [DATA_W:0]   data2,
  input  logic              data2_valid,
  output logic              data2_ready,
  output logic [DATA_W-1:0] pe_op0,
  output logic [DATA_W-1:0] pe_op1,
  output logic [DATA_W-1:0] pe_op2,
  input  logic [DATA_W-1:0] pe_res,
  output logic [DATA_W:0]   res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int SW    = DATA_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;

  // state  | meaning
  // IDLE   | waiting for tile_en
  // RUN    | joining operands and firing
  // DONE   | DONE token pushed; held until flush or tile_en low
  // ERR    | token misalignment seen; held until flush or tile_en low
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]    data_arr [3];
  logic [2:0]       valid_vec;
  logic             all_v, any_v, pop, full_after_pop, fire, push, err_ev;
  logic             all_data, all_tok, have_ref;
  logic [SW-1:0]    ref_val, push_val;
  logic [SW-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic             started;

  assign data_arr[0] = data0;
  assign data_arr[1] = data1;
  assign data_arr[2] = data2;
  assign valid_vec   = {data2_valid, data1_valid, data0_valid};

  assign all_v = (in_mask != 3'b000) && ((valid_vec | ~in_mask) == 3'b111);
  assign any_v = |(valid_vec & in_mask);

  assign res_valid      = (fifo_cnt != '0);
  assign res            = mem[rd_ptr];
  assign pop            = clk_en && res_valid && res_ready;
  assign full_after_pop = (fifo_cnt == CW'(FIFO_DEPTH)) && !pop;
  assign fire = clk_en && !flush && tile_en && (state == S_RUN) && all_v && !full_after_pop;

  assign data0_ready = fire && in_mask[0];
  assign data1_ready = fire && in_mask[1];
  assign data2_ready = fire && in_mask[2];

  assign pe_op0 = in_mask[0] ? data0[DATA_W-1:0] : '0;
  assign pe_op1 = in_mask[1] ? data1[DATA_W-1:0] : '0;
  assign pe_op2 = in_mask[2] ? data2[DATA_W-1:0] : '0;

  // Tokens pass only if every enabled lane carries the same token as the lowest enabled lane.
  always_comb begin
    ref_val  = '0;
    have_ref = 1'b0;
    all_data = 1'b1;
    all_tok  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (in_mask[i]) begin
        if (!have_ref) begin
          ref_val  = data_arr[i];
          have_ref = 1'b1;
        end
        if (data_arr[i][SW-1]) all_data = 1'b0;
        else                   all_tok  = 1'b0;
        if (data_arr[i] != ref_val) all_tok = 1'b0;
      end
    end
  end

  assign push     = fire && (all_data || all_tok);
  assign err_ev   = fire && !all_data && !all_tok;
  assign push_val = all_data ? {1'b0, pe_res} : ref_val;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else if (clk_en) begin
      case (state)
        S_IDLE: if (tile_en) state_nxt = S_RUN;
        S_RUN: begin
          if (err_ev)                               state_nxt = S_ERR;
          else if (push && push_val == DONE_TOKEN)  state_nxt = S_DONE;
          else if (!tile_en)                        state_nxt = S_IDLE;
        end
        S_DONE, S_ERR: if (!tile_en) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_val;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      error <= 1'b0;
    else if (flush)  error <= 1'b0;
    else if (err_ev) error <= 1'b1;
  end

  // Counting starts with the first enabled valid in RUN and then runs every enabled RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      started     <= 1'b0;
    end else if (flush) begin
      cycle_count <= '0;
      started     <= 1'b0;
    end else if (clk_en && state == S_RUN && (started || any_v)) begin
      started <= 1'b1;
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pe_stream_sequencer.sv
// Directed bench for pe_stream_sequencer with an adder standing in for the PE.
module tb_pe_stream_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, tile_en, res_ready;
  logic [2:0]  in_mask;
  logic [16:0] data0, data1, data2;
  logic        data0_valid, data1_valid, data2_valid;
  logic        data0_ready, data1_ready, data2_ready;
  logic [15:0] pe_op0, pe_op1, pe_op2, pe_res;
  logic [16:0] res;
  logic        res_valid, done, error;
  logic [31:0] cycle_count;
  int checks = 0;
  int errors = 0;
  localparam logic [16:0] D = 17'h10100;

  always #5 clk = ~clk;
  assign pe_res = pe_op0 + pe_op1 + pe_op2;

  pe_stream_sequencer dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .in_mask(in_mask),
    .data0(data0), .data0_valid(data0_valid), .data0_ready(data0_ready),
    .data1(data1), .data1_valid(data1_valid), .data1_ready(data1_ready),
    .data2(data2), .data2_valid(data2_valid), .data2_ready(data2_ready),
    .pe_op0(pe_op0), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_res(pe_res),
    .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .done(done), .error(error), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [16:0] d0, input logic v1,
                       input logic [16:0] d1, input logic v2, input logic [16:0] d2);
    data0_valid = v0; data0 = d0;
    data1_valid = v1; data1 = d1;
    data2_valid = v2; data2 = d2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] s0 [3];
    logic [16:0] s1 [3];
    logic [16:0] ex [3];
    s0[0] = 17'd5; s0[1] = 17'd7; s0[2] = D;
    s1[0] = 17'd2; s1[1] = 17'd3; s1[2] = D;
    ex[0] = 17'd7; ex[1] = 17'd10; ex[2] = D;

    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b0; res_ready = 1'b1;
    in_mask = 3'b011;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_res", 32'(res), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_count", cycle_count, 32'h0);
    chk("rst_readys", 32'({data2_ready, data1_ready, data0_ready}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: two-operand add, then DONE token
    drive(1, s0[0], 1, s1[0], 0, 17'd9);
    #1 chk("idle_ready", 32'(data0_ready), 32'h0);
    tile_en = 1'b1;
    tick();
    #1 chk("t1_readys", 32'({data2_ready, data1_ready, data0_ready}), 32'h3);
    chk("t1_op0", 32'(pe_op0), 32'd5);
    chk("t1_op2_masked", 32'(pe_op2), 32'd0);
    tick();
    chk("t1_res0", 32'(res), 32'd7);
    chk("t1_res0_valid", 32'(res_valid), 32'h1);
    chk("t1_count1", cycle_count, 32'd1);
    drive(1, s0[1], 1, s1[1], 0, 0);
    tick();
    chk("t1_res1", 32'(res), 32'd10);
    drive(1, D, 1, D, 0, 0);
    #1 chk("t1_tok_ready", 32'(data0_ready), 32'h1);
    tick();
    chk("t1_res_tok", 32'(res), 32'h10100);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_count3", cycle_count, 32'd3);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t1_drained", 32'(res_valid), 32'h0);
    chk("t1_count_held", cycle_count, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", cycle_count, 32'd0);
    chk("flush_done", 32'(done), 32'h0);

    // Test 2: three operands, in1 late by 4 cycles
    in_mask = 3'b111;
    tick();
    drive(1, 17'd1, 0, 17'd10, 1, 17'd100);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_wait_ready", 32'({data2_ready, data1_ready, data0_ready}), 32'h0);
      tick();
    end
    chk("t2_wait_empty", 32'(res_valid), 32'h0);
    chk("t2_wait_count", cycle_count, 32'd4);
    data1_valid = 1'b1;
    #1 chk("t2_readys", 32'({data2_ready, data1_ready, data0_ready}), 32'h7);
    tick();
    chk("t2_res0", 32'(res), 32'd111);
    drive(1, 17'd2, 1, 17'd20, 1, 17'd200);
    tick();
    chk("t2_res1", 32'(res), 32'd222);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t2_drained", 32'(res_valid), 32'h0);
    chk("t2_count", cycle_count, 32'd7);

    // Test 3: backpressure for 6 cycles
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_mask = 3'b011;
    tick();
    res_ready = 1'b0;
    drive(1, 17'd1, 1, 17'd1, 0, 0);
    tick();
    drive(1, 17'd2, 1, 17'd2, 0, 0);
    #1 chk("t3_second_ready", 32'(data0_ready), 32'h1);
    tick();
    drive(1, 17'd3, 1, 17'd3, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_full_ready", 32'({data1_ready, data0_ready}), 32'h0);
      chk("t3_full_head", 32'(res), 32'd2);
      tick();
    end
    res_ready = 1'b1;
    #1 chk("t3_pop_frees_slot", 32'(data0_ready), 32'h1);
    tick();
    chk("t3_res_a", 32'(res), 32'd4);
    drive(1, 17'd4, 1, 17'd4, 0, 0);
    tick();
    chk("t3_res_b", 32'(res), 32'd6);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t3_res_c", 32'(res), 32'd8);
    tick();
    chk("t3_drained", 32'(res_valid), 32'h0);

    // Test 4: token/data misalignment
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    drive(1, 17'h10001, 1, 17'h00004, 0, 0);
    #1 chk("t4_consume", 32'(data0_ready), 32'h1);
    tick();
    chk("t4_error", 32'(error), 32'h1);
    chk("t4_no_output", 32'(res_valid), 32'h0);
    #1 chk("t4_err_ready", 32'({data1_ready, data0_ready}), 32'h0);
    tick();
    chk("t4_still_empty", 32'(res_valid), 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_flush_error", 32'(error), 32'h0);

    // Test 5: async reset with two results buffered
    tick();
    res_ready = 1'b0;
    drive(1, 17'd1, 1, 17'd2, 0, 0);
    tick();
    drive(1, 17'd3, 1, 17'd4, 0, 0);
    tick();
    chk("t5_head", 32'(res), 32'd3);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(res_valid), 32'h0);
    chk("t5_rst_res", 32'(res), 32'h0);
    chk("t5_rst_count", cycle_count, 32'h0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();

    // Test 6: test 1 with clk_en toggling
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, s0[i], 1, s1[i], 0, 0);
      clk_en = 1'b0;
      #1 chk("t6_gated_ready", 32'(data0_ready), 32'h0);
      tick();
      chk("t6_hold_valid", 32'(res_valid), (i == 0) ? 32'h0 : 32'h1);
      if (i > 0) chk("t6_hold_res", 32'(res), 32'(ex[i-1]));
      clk_en = 1'b1;
      #1 chk("t6_ready", 32'(data0_ready), 32'h1);
      tick();
      chk("t6_res", 32'(res), 32'(ex[i]));
    end
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_count", cycle_count, 32'd3);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("t6_drained", 32'(res_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
